// File: rtl/seq_div_pkg.sv
// Shared state encoding and default width for the sequential divider.
// The default width matches the shift-add multiplier's operands.
package seq_div_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// then trial-subtract the divisor and keep the result when it fits.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {r, q_msb};
    trial   = shifted - {1'b0, d};
    q_bit   = ~trial[WIDTH];
    r_next  = q_bit ? trial[WIDTH-1:0]
                    : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock,
// with start/busy/done handshake matching the shift-add multiplier.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q_msb  (q_q[WIDTH-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        r_d   = step_r;
        q_d   = {q_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - CW'(1);
        // results load on entry so they are valid alongside done
        if (cnt_q == CW'(1)) begin
          quo_d   = q_d;
          rem_d   = step_r;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep checks of seq_divider at WIDTH=4,
// plus a WIDTH=8 instance exercised with random operands.
module tb_seq_divider;

  logic       clk;
  logic       rstN;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] q8;
  logic [7:0] r8;
  logic       z8;

  int tests = 0;
  int fails = 0;
  logic [3:0] pq = '0;
  logic [3:0] pr = '0;

  seq_divider #(.WIDTH(4)) u_dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start8),
    .dividend    (a8),
    .divisor     (b8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Caller is #1 after an edge; returns #1 after the edge
  // that brings the divider back to IDLE.
  task automatic div4(input string tag,
                      input logic [3:0] a,
                      input logic [3:0] b,
                      input logic [3:0] eq,
                      input logic [3:0] er,
                      input logic       ez,
                      input logic       hold);
    int edc, nb, nd, nh;
    edc = (b == 4'd0) ? 1 : 5;
    nb = 0; nd = 0; nh = 0;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    if (hold) begin
      dividend = 4'd1; divisor = 4'd1;
    end else begin
      start = 1'b0; dividend = ~a; divisor = ~b;
    end
    for (int c = 1; c <= edc + 1; c++) begin
      if (busy !== (c <= edc)) nb++;
      if (done !== (c == edc)) nd++;
      if (c < edc && (quotient !== pq || remainder !== pr)) nh++;
      if (c == edc) begin
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_z"}, div_by_zero, ez);
        start = 1'b0;
      end
      if (c <= edc) begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_busy"}, nb, 0);
    chk({tag, "_done"}, nd, 0);
    chk({tag, "_hold"}, nh, 0);
    chk({tag, "_keep"}, {quotient, remainder}, {eq, er});
    pq = eq; pr = er;
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b);
    int edc, dc;
    logic [7:0] eq, er;
    if (b == 8'd0) begin
      edc = 1; eq = 8'hFF; er = a;
    end else begin
      edc = 9; eq = a / b; er = a % b;
    end
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    dc = 0;
    for (int c = 1; c <= 12 && dc == 0; c++) begin
      if (done8) begin
        dc = c;
        chk("w8_q", q8, eq);
        chk("w8_r", r8, er);
        chk("w8_z", z8, b == 8'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("w8_lat", dc, edc);
    @(posedge clk); #1;
  endtask

  initial begin
    int nd;
    rstN = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 4'd0);
    chk("rst_r", remainder, 4'd0);
    chk("rst_z", div_by_zero, 1'b0);
    rstN = 1'b1;
    @(posedge clk); #1;

    div4("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0);
    div4("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0);
    div4("d2_7", 4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 1'b0);
    div4("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1'b0);
    div4("d8_2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 1'b0);
    div4("d12_5h", 4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b1);

    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_q", quotient, 4'd0);
    chk("mid_rst_r", remainder, 4'd0);
    chk("mid_rst_z", div_by_zero, 1'b0);
    @(posedge clk); #1;
    rstN = 1'b1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("mid_rst_quiet", nd, 0);
    pq = '0; pr = '0;
    div4("d14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          div4("sweep", 4'(a), 4'd0, 4'd15, 4'(a), 1'b1, 1'b0);
        else
          div4("sweep", 4'(a), 4'(b), 4'(a / b), 4'(a % b),
               1'b0, 1'b0);
      end
    end

    div8(8'd200, 8'd0);
    div8(8'd255, 8'd1);
    div8(8'd7, 8'd255);
    for (int i = 0; i < 24; i++)
      div8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
